// File: rtl/byte_seq_checker.sv
// byte_seq_checker
//   Consumes the per-clock byte pair {byt, byts} from the counter stage.
//   byt must equal AUTO_EXP on every valid sample. byts must advance by STEP
//   (mod 256) per valid sample. Valid samples and errored samples are counted,
//   both saturating. Each errored sample queues a record in a DEPTH-entry FIFO,
//   and the consumer drains that FIFO over evt_valid/evt_ready.
//
//   Optional feature macro: BSC_WRAP_CNT_EN adds the wrap_cnt output. wrap_cnt
//   counts TRACK samples where the static check passes and byts wrapped below
//   the reference.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   byt/byts carry a sample this cycle
//   byt        automatic-path byte, expected constant AUTO_EXP
//   byts       static-path byte, expected to step by STEP
//   evt_valid  FIFO head holds an event
//   evt_ready  consumer takes the head this cycle
//   evt_data   {kind[1:0], idx[15:0], byt[7:0], byts[7:0]}
//                kind: 01 = auto fail, 10 = static fail, 11 = both
//   smp_cnt    valid samples seen (saturating)
//   err_cnt    samples with any mismatch (saturating)
//   locked     the last static compare passed
//   ovf        sticky: an event was dropped because the FIFO was full
//   wrap_cnt   wrap count (only with BSC_WRAP_CNT_EN)
module byte_seq_checker #(
   parameter logic [7:0]  AUTO_EXP = 8'd1,
   parameter logic [7:0]  STEP     = 8'd1,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  byt,
   input  logic [7:0]  byts,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic [33:0] evt_data,
   output logic [15:0] smp_cnt,
   output logic [15:0] err_cnt,
   output logic        locked,
   output logic        ovf
`ifdef BSC_WRAP_CNT_EN
   ,
   output logic [15:0] wrap_cnt
`endif
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   typedef enum logic {SYNC, TRACK} state_t;

   state_t        state_q, state_d;
   logic [7:0]    ref_q;
   logic          auto_fail, stat_fail, push, pop, full, accept, drop;
   logic [1:0]    kind;
   logic [33:0]   rec;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [33:0]   mem [DEPTH];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= SYNC;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (in_valid) state_d = TRACK;
   end

   // ---------------- FSM: outputs / per-sample decisions ----------------
   always_comb begin
      auto_fail = in_valid && (byt != AUTO_EXP);
      stat_fail = in_valid && (state_q == TRACK) && (byts != 8'(ref_q + STEP));
      kind      = {stat_fail, auto_fail};
      push      = auto_fail || stat_fail;
      rec       = {kind, smp_cnt, byt, byts};
      pop       = evt_valid && evt_ready;
      full      = (count == DEPTH_C);
      // A pop in the same cycle frees the slot, so a push into a full FIFO
      // is only dropped when nothing leaves.
      accept    = push && (!full || pop);
      drop      = push && full && !pop;
   end

   // ---------------- sample bookkeeping ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_q   <= '0;
         locked  <= 1'b0;
         smp_cnt <= '0;
         err_cnt <= '0;
         ovf     <= 1'b0;
      end else begin
         if (in_valid) begin
            // Always resync to the received byte so that one glitch yields one error.
            ref_q <= byts;
            if (state_q == TRACK) locked <= !stat_fail;
            if (smp_cnt != '1) smp_cnt <= smp_cnt + 16'd1;
         end
         if (push && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
         if (drop) ovf <= 1'b1;
      end
   end

`ifdef BSC_WRAP_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_cnt <= '0;
      end else if (in_valid && (state_q == TRACK) && !stat_fail && (byts < ref_q)
                   && (wrap_cnt != '1)) begin
         wrap_cnt <= wrap_cnt + 16'd1;
      end
   end
`endif

   // ---------------- event FIFO ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= rec;
   end

   assign evt_valid = (count != '0);
   assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_byte_seq_checker.sv
// tb_byte_seq_checker
//   Directed scenarios plus a randomized stream for byte_seq_checker. Every
//   output is compared after every clock against a queue-based reference model
//   built from the checking rules.
module tb_byte_seq_checker;

   localparam logic [7:0] AUTO_EXP = 8'd1;
   localparam logic [7:0] STEP     = 8'd1;
   localparam int         DEPTH    = 4;

   logic        clk = 1'b0;
   logic        rst, in_valid, evt_ready;
   logic [7:0]  byt, byts;
   logic        evt_valid, locked, ovf;
   logic [33:0] evt_data;
   logic [15:0] smp_cnt, err_cnt;
`ifdef BSC_WRAP_CNT_EN
   logic [15:0] wrap_cnt;
`endif

   byte_seq_checker #(
      .AUTO_EXP (AUTO_EXP),
      .STEP     (STEP),
      .DEPTH    (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .byt       (byt),
      .byts      (byts),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_data  (evt_data),
      .smp_cnt   (smp_cnt),
      .err_cnt   (err_cnt),
      .locked    (locked),
      .ovf       (ovf)
`ifdef BSC_WRAP_CNT_EN
      ,
      .wrap_cnt  (wrap_cnt)
`endif
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // reference model
   int          m_smp, m_err, m_wrap, m_ref;
   bit          m_synced, m_locked, m_ovf;
   logic [33:0] m_q[$];

   task automatic model_reset();
      m_smp = 0; m_err = 0; m_wrap = 0; m_ref = 0;
      m_synced = 0; m_locked = 0; m_ovf = 0;
      m_q.delete();
   endtask

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_all();
      chk("smp_cnt",   34'(smp_cnt),   34'(m_smp));
      chk("err_cnt",   34'(err_cnt),   34'(m_err));
      chk("locked",    34'(locked),    34'(m_locked));
      chk("ovf",       34'(ovf),       34'(m_ovf));
      chk("evt_valid", 34'(evt_valid), 34'(m_q.size() != 0));
      if (m_q.size() != 0) chk("evt_data", evt_data, m_q[0]);
`ifdef BSC_WRAP_CNT_EN
      chk("wrap_cnt",  34'(wrap_cnt),  34'(m_wrap));
`endif
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic step(input bit v, input logic [7:0] b, input logic [7:0] bs, input bit rdy);
      bit          af, sf, popped;
      logic [33:0] dummy;
      @(negedge clk);
      in_valid = v; byt = b; byts = bs; evt_ready = rdy;
      popped = rdy && (m_q.size() != 0);
      if (popped) dummy = m_q.pop_front();
      if (v) begin
         af = (b != AUTO_EXP);
         sf = m_synced && (bs != 8'(m_ref + STEP));
         if (m_synced) begin
            m_locked = !sf;
            if (!sf && (bs < m_ref) && m_wrap < 65535) m_wrap++;
         end
         if (af || sf) begin
            if (m_err < 65535) m_err++;
            if (m_q.size() < DEPTH) m_q.push_back({sf, af, 16'(m_smp), b, bs});
            else                    m_ovf = 1;
         end
         if (m_smp < 65535) m_smp++;
         m_ref    = bs;
         m_synced = 1;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      in_valid = 1'b0; evt_ready = 1'b0; byt = '0; byts = '0;
      #1;
      chk("rst_smp",   34'(smp_cnt),   '0);
      chk("rst_err",   34'(err_cnt),   '0);
      chk("rst_lock",  34'(locked),    '0);
      chk("rst_ovf",   34'(ovf),       '0);
      chk("rst_valid", 34'(evt_valid), '0);
      chk("rst_data",  evt_data,       '0);
`ifdef BSC_WRAP_CNT_EN
      chk("rst_wrap",  34'(wrap_cnt),  '0);
`endif
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; evt_ready = 1'b0; byt = '0; byts = '0;
      model_reset();
      repeat (2) @(negedge clk);

      // T1: clean stream
      do_reset();
      step(1, 8'd1, 8'd5, 0);
      chk("T1_lock_sync", 34'(locked), 34'(0));
      step(1, 8'd1, 8'd6, 0);
      chk("T1_lock", 34'(locked), 34'(1));
      step(1, 8'd1, 8'd7, 0);
      chk("T1_smp", 34'(smp_cnt), 34'(3));
      chk("T1_evt", 34'(evt_valid), 34'(0));

      // T2: auto-path error only
      do_reset();
      step(1, 8'd1, 8'd10, 0);
      step(1, 8'd1, 8'd11, 0);
      step(1, 8'd0, 8'd12, 0);
      chk("T2_data", evt_data, {2'b01, 16'd2, 8'h00, 8'h0C});
      chk("T2_lock", 34'(locked), 34'(1));

      // T3: static glitch resyncs after one error
      do_reset();
      step(1, 8'd1, 8'd20, 0);
      step(1, 8'd1, 8'd21, 0);
      step(1, 8'd1, 8'd40, 0);
      chk("T3_lock0", 34'(locked), 34'(0));
      chk("T3_data", evt_data, {2'b10, 16'd2, 8'd1, 8'd40});
      step(1, 8'd1, 8'd41, 0);
      chk("T3_lock1", 34'(locked), 34'(1));
      chk("T3_err", 34'(err_cnt), 34'(1));

      // T4: overflow, then drain in order
      do_reset();
      step(1, 8'd1, 8'd0, 0);
      for (int i = 1; i <= DEPTH + 1; i++) step(1, 8'd0, 8'(i), 0);
      chk("T4_ovf", 34'(ovf), 34'(1));
      chk("T4_err", 34'(err_cnt), 34'(DEPTH + 1));
      for (int i = 1; i <= DEPTH; i++) begin
         chk("T4_idx", 34'(evt_data[31:16]), 34'(i));
         step(0, 8'd0, 8'd0, 1);
      end
      step(0, 8'd0, 8'd0, 1);
      chk("T4_empty", 34'(evt_valid), 34'(0));

      // T5: push into full FIFO with a same-cycle pop
      do_reset();
      step(1, 8'd1, 8'd0, 0);
      for (int i = 1; i <= DEPTH; i++) step(1, 8'd0, 8'(i), 0);
      step(1, 8'd0, 8'(DEPTH + 1), 1);
      chk("T5_ovf", 34'(ovf), 34'(0));
      for (int i = 0; i < DEPTH; i++) begin
         chk("T5_occ", 34'(evt_valid), 34'(1));
         step(0, 8'd0, 8'd0, 1);
      end
      chk("T5_empty", 34'(evt_valid), 34'(0));

      // T6: wrap through 0xFF, then reset mid-stream
      do_reset();
      step(1, 8'd1, 8'hFE, 0);
      step(1, 8'd1, 8'hFF, 0);
      step(1, 8'd1, 8'h00, 0);
      chk("T6_err", 34'(err_cnt), 34'(0));
`ifdef BSC_WRAP_CNT_EN
      chk("T6_wrap", 34'(wrap_cnt), 34'(1));
`endif
      step(1, 8'd1, 8'h01, 0);
      do_reset();
      step(1, 8'd1, 8'h33, 0);
      chk("T6_resync_err", 34'(err_cnt), 34'(0));
      step(1, 8'd1, 8'h34, 0);
      chk("T6_resync_lock", 34'(locked), 34'(1));

      // randomized stream
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic [7:0] rb, rbs;
         rb  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : AUTO_EXP;
         rbs = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(m_ref + STEP);
         step($urandom_range(0, 3) != 0, rb, rbs, $urandom_range(0, 2) != 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
